svi_chan_scanner: RTL and testbench
===================================

# svi_chan_scanner

Parametrised multi-channel capture-and-scan block for SVI channel arrays. It holds one W-bit register per channel, loaded by per-channel update strobes. A round-robin scanner serialises channels onto a single valid/ready output stream. MODE 0 emits every channel in turn; MODE 1 emits only channels whose value changed. It sits between an array of SVI producers and a single serial consumer (debug/trace port or top-level output mux).

## Interface
- NCH, 8: number of channels; legal range 2..64.
- W, 1: data width per channel; legal range 1..32.
- MODE, 0: 0 = continuous round-robin scan; 1 = change-driven scan (dirty channels only).
- IDXW, derived: $clog2(NCH); not overridable.

- i_clk  in  1  clock; all state updates on the rising edge.
- i_arst  in  1  asynchronous, active-high reset.
- i_en  in  1  global capture enable; gates all i_upd strobes.
- i_upd  in  NCH  per-channel capture strobe.
- i_data  in  NCH*W  channel c occupies bits [c*W +: W].
- o_q  out  NCH*W  current channel registers, same packing as i_data.
- o_valid  out  1  output beat valid.
- i_ready  in  1  consumer accepts the beat when o_valid && i_ready.
- o_idx  out  IDXW  channel index of the current beat.
- o_data  out  W  snapshot of that channel's value at load time.
- o_dirty  out  NCH  per-channel pending-change flags; always 0 in MODE 0.

## Operation
- **Capture.** At each edge where i_en && i_upd[c]: q[c] <= i_data[c].
  - MODE 1 only: if the new value differs from q[c], set dirty[c] <= 1.
  - An identical value leaves dirty[c] unchanged.
- **Output register.**
  - One-entry stage made of o_valid, o_idx and o_data.
  - Loads are permitted when !o_valid || i_ready.
  - While o_valid && !i_ready, o_idx and o_data are held stable.
- **Scan pointer.**
  - ptr has width IDXW and resets to 0.
  - It wraps from NCH-1 to 0 with no idle cycle.
- **MODE 0.**
  - Every permitted load takes sel = ptr, sets o_data = q[sel], and sets o_valid = 1.
  - Then ptr <= sel+1 (with wrap).
  - After reset, o_valid goes high at the first edge and stays high; it never drops.
- **MODE 1.**
  - On a permitted load, sel is the first set dirty bit found by a circular search starting at ptr.
  - If a channel is found: load it, clear dirty[sel], and set ptr <= sel+1 (with wrap).
  - If none is found: o_valid <= 0 and ptr is unchanged.
- **Load vs. capture in the same edge (MODE 1).**
  - If channel sel is loaded and also captured with a changed value at the same edge, o_data takes the old q[sel] and dirty[sel] stays 1.
  - In this case capture wins over clear.
- **Search scope.** The dirty search uses registered dirty bits only; captures at the same edge are not visible to it.
- **i_en low.** No captures occur; scanning continues.
- **Reset (asynchronous, immediate).** All of the following clear to 0:
  - q (so o_q = 0), dirty (so o_dirty = 0), ptr;
  - o_valid, o_idx, o_data.
  - A beat in flight is dropped, not replayed.

## Timing
- **Capture to o_q:** 1 cycle. o_q reflects i_data at the edge where the strobe is sampled.
- **MODE 1, capture to o_valid:** 2 edges.
  - Edge k: capture sets dirty.
  - Edge k+1: the load occurs, if the output stage is free.
- **Throughput:** 1 beat/cycle when i_ready = 1.
  - MODE 0: a full sweep takes NCH cycles.
- **Fairness (MODE 1):** a dirty channel is emitted within NCH accepted beats, regardless of traffic on other channels.
- **Reset release:** the first permitted load is at the first rising edge after i_arst deasserts.

## Test plan
- **MODE 0 sweep** (NCH=8, W=4, q[c]=c+1, i_ready=1):
  - o_idx steps 0,1,...,7,0 on consecutive cycles.
  - o_data = idx+1.
  - No bubble at the 7→0 wrap.
- **Backpressure** (MODE 0): hold i_ready=0 for 5 cycles with o_idx=3.
  - o_idx=3 and o_data stay stable throughout.
  - On release, the next beat is idx 4.
- **MODE 1 change detection:**
  - Write ch2=0xA, ch6=0x5 at the same edge → beats idx2 then idx6; then o_valid=0.
  - Rewrite ch2=0xA → no beat.
  - Write ch2=0xB → one beat: idx2, data 0xB.
- **MODE 1 capture/load collision:** ch3 dirty with value 0x1; capture 0x2 at the load edge.
  - Beat idx3 carries data 0x1.
  - dirty[3] remains 1.
  - The next beat is idx3 carrying 0x2.
- **Circular fairness** (MODE 1): keep ch0 re-dirtied every cycle while ch5 is dirty and ptr=1.
  - ch5 is emitted before ch0 repeats.
  - Beat order: 5, 0, 0, ...
- **Async reset mid-stream:** assert i_arst between edges while o_valid=1, idx=4.
  - o_valid, o_idx, o_data, o_q and o_dirty go to 0 immediately, without waiting for a clock edge.
  - After release: MODE 0 restarts at idx 0; MODE 1 stays idle.

Source files
------------

// File: rtl/svi_chan_scanner.sv
// rtl/svi_chan_scanner.sv - per-channel capture registers with round-robin serial scan
// MODE 0 streams every channel in turn; MODE 1 streams only channels whose value changed.
module svi_chan_scanner #(
   parameter int NCH  = 8,
   parameter int W    = 1,
   parameter int MODE = 0,
   localparam int IDXW = $clog2(NCH)
) (
   input  logic             i_clk,
   input  logic             i_arst,
   input  logic             i_en,
   input  logic [NCH-1:0]   i_upd,
   input  logic [NCH*W-1:0] i_data,
   output logic [NCH*W-1:0] o_q,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [IDXW-1:0]  o_idx,
   output logic [W-1:0]     o_data,
   output logic [NCH-1:0]   o_dirty
);

   localparam int SW = IDXW + 1;

   logic [NCH*W-1:0] r_q;
   logic [NCH-1:0]   r_dirty;
   logic [IDXW-1:0]  r_ptr;
   logic             r_valid;
   logic [IDXW-1:0]  r_idx;
   logic [W-1:0]     r_data;

   logic             w_load;
   logic             w_found;
   logic [IDXW-1:0]  w_sel;
   logic [IDXW-1:0]  w_ptr_nxt;
   logic [SW-1:0]    w_pos;
   logic [W-1:0]     w_sel_data;
   logic [NCH-1:0]   w_cap;
   logic [NCH-1:0]   w_chg;
   logic [NCH-1:0]   w_dirty_nxt;

   assign w_load = !r_valid || i_ready;

   // Circular search from r_ptr over registered dirty bits; w_pos is kept one bit wider to wrap.
   always_comb begin
      w_found = 1'b0;
      w_sel   = r_ptr;
      w_pos   = '0;
      if (MODE == 0) begin
         w_found = 1'b1;
      end else begin
         for (int k = 0; k < NCH; k++) begin
            w_pos = {1'b0, r_ptr} + SW'(k);
            if (w_pos >= SW'(NCH)) begin
               w_pos = w_pos - SW'(NCH);
            end
            if (!w_found && r_dirty[w_pos[IDXW-1:0]]) begin
               w_found = 1'b1;
               w_sel   = w_pos[IDXW-1:0];
            end
         end
      end
   end

   always_comb begin
      w_sel_data = '0;
      for (int c = 0; c < NCH; c++) begin
         if (w_sel == IDXW'(c)) begin
            w_sel_data = r_q[c*W +: W];
         end
      end
   end

   assign w_ptr_nxt = (w_sel == IDXW'(NCH - 1)) ? '0 : w_sel + 1'b1;

   always_comb begin
      w_cap = '0;
      w_chg = '0;
      for (int c = 0; c < NCH; c++) begin
         w_cap[c] = i_en && i_upd[c];
         w_chg[c] = w_cap[c] && (i_data[c*W +: W] != r_q[c*W +: W]);
      end
   end

   // A change captured on the channel being loaded re-arms it: set is applied after clear.
   always_comb begin
      w_dirty_nxt = r_dirty;
      if (MODE == 0) begin
         w_dirty_nxt = '0;
      end else begin
         if (w_load && w_found) begin
            w_dirty_nxt[w_sel] = 1'b0;
         end
         w_dirty_nxt = w_dirty_nxt | w_chg;
      end
   end

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         r_q     <= '0;
         r_dirty <= '0;
         r_ptr   <= '0;
         r_valid <= 1'b0;
         r_idx   <= '0;
         r_data  <= '0;
      end else begin
         for (int c = 0; c < NCH; c++) begin
            if (w_cap[c]) begin
               r_q[c*W +: W] <= i_data[c*W +: W];
            end
         end
         r_dirty <= w_dirty_nxt;
         if (w_load) begin
            if (w_found) begin
               r_valid <= 1'b1;
               r_idx   <= w_sel;
               r_data  <= w_sel_data;
               r_ptr   <= w_ptr_nxt;
            end else begin
               r_valid <= 1'b0;
            end
         end
      end
   end

   assign o_q     = r_q;
   assign o_dirty = r_dirty;
   assign o_valid = r_valid;
   assign o_idx   = r_idx;
   assign o_data  = r_data;

endmodule

// File: tb/tb_svi_chan_scanner.sv
// tb/tb_svi_chan_scanner.sv - directed and random checks of both scan modes
// Two instances (MODE 0 and MODE 1) share capture inputs and are tracked by one array-based model.
module tb_svi_chan_scanner;

   localparam int NCH  = 8;
   localparam int W    = 4;
   localparam int IDXW = 3;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             en  = 1'b0;
   logic             rdy0 = 1'b1;
   logic             rdy1 = 1'b1;
   logic [NCH-1:0]   upd = '0;
   logic [NCH*W-1:0] din;
   logic [W-1:0]     drv [NCH];

   logic [NCH*W-1:0] q0, q1;
   logic             v0, v1;
   logic [IDXW-1:0]  idx0, idx1;
   logic [W-1:0]     d0, d1;
   logic [NCH-1:0]   dirty0, dirty1;

   int checks = 0;
   int errors = 0;

   int mq [NCH];
   int mdirty [NCH];
   int mptr [2];
   int mvalid [2];
   int midx [2];
   int mdata [2];

   always #5 clk = ~clk;

   always_comb begin
      din = '0;
      for (int c = 0; c < NCH; c++) din[c*W +: W] = drv[c];
   end

   svi_chan_scanner #(.NCH(NCH), .W(W), .MODE(0)) u_m0 (
      .i_clk(clk), .i_arst(rst), .i_en(en), .i_upd(upd), .i_data(din),
      .o_q(q0), .o_valid(v0), .i_ready(rdy0), .o_idx(idx0), .o_data(d0), .o_dirty(dirty0));

   svi_chan_scanner #(.NCH(NCH), .W(W), .MODE(1)) u_m1 (
      .i_clk(clk), .i_arst(rst), .i_en(en), .i_upd(upd), .i_data(din),
      .o_q(q1), .o_valid(v1), .i_ready(rdy1), .o_idx(idx1), .o_data(d1), .o_dirty(dirty1));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         mq[c] = 0;
         mdirty[c] = 0;
      end
      for (int m = 0; m < 2; m++) begin
         mptr[m] = 0; mvalid[m] = 0; midx[m] = 0; mdata[m] = 0;
      end
   endtask

   // One clock edge: loads see pre-edge q/dirty, then captures apply (so capture beats clear).
   task automatic model_edge();
      int ready [2];
      int found, sel, c;
      ready[0] = rdy0;
      ready[1] = rdy1;
      for (int m = 0; m < 2; m++) begin
         if (!mvalid[m] || ready[m] != 0) begin
            found = 0;
            sel = 0;
            if (m == 0) begin
               found = 1;
               sel = mptr[0];
            end else begin
               for (int k = 0; k < NCH; k++) begin
                  c = (mptr[1] + k) % NCH;
                  if (!found && mdirty[c] != 0) begin
                     found = 1;
                     sel = c;
                  end
               end
            end
            if (found != 0) begin
               mvalid[m] = 1;
               midx[m] = sel;
               mdata[m] = mq[sel];
               mptr[m] = (sel + 1) % NCH;
               if (m == 1) mdirty[sel] = 0;
            end else begin
               mvalid[m] = 0;
            end
         end
      end
      for (int i = 0; i < NCH; i++) begin
         if (en && upd[i]) begin
            if (int'(drv[i]) != mq[i]) mdirty[i] = 1;
            mq[i] = int'(drv[i]);
         end
      end
   endtask

   task automatic compare_all();
      logic [NCH*W-1:0] eq;
      logic [NCH-1:0]   ed;
      for (int c = 0; c < NCH; c++) begin
         eq[c*W +: W] = W'(mq[c]);
         ed[c] = (mdirty[c] != 0);
      end
      chk("m0_q", 64'(q0), 64'(eq));
      chk("m1_q", 64'(q1), 64'(eq));
      chk("m0_dirty", 64'(dirty0), 64'(0));
      chk("m1_dirty", 64'(dirty1), 64'(ed));
      chk("m0_valid", 64'(v0), 64'(mvalid[0]));
      chk("m1_valid", 64'(v1), 64'(mvalid[1]));
      if (mvalid[0] != 0) begin
         chk("m0_idx", 64'(idx0), 64'(midx[0]));
         chk("m0_data", 64'(d0), 64'(mdata[0]));
      end
      if (mvalid[1] != 0) begin
         chk("m1_idx", 64'(idx1), 64'(midx[1]));
         chk("m1_data", 64'(d1), 64'(mdata[1]));
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int guard;
      for (int c = 0; c < NCH; c++) drv[c] = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      compare_all();
      chk("rst_v0", 64'(v0), 64'(0));
      chk("rst_q0", 64'(q0), 64'(0));
      rst = 1'b0;

      // MODE 0 sweep with q[c] = c+1
      for (int c = 0; c < NCH; c++) drv[c] = W'(c + 1);
      upd = '1;
      en = 1'b1;
      step();
      chk("sweep_first_idx", 64'(idx0), 64'(0));
      chk("sweep_first_valid", 64'(v0), 64'(1));
      upd = '0;
      en = 1'b0;
      for (int i = 1; i <= 11; i++) begin
         step();
         chk("sweep_valid", 64'(v0), 64'(1));
         chk("sweep_idx", 64'(idx0), 64'(i % NCH));
         chk("sweep_data", 64'(d0), 64'((i % NCH) + 1));
      end

      // Backpressure on idx 3
      rdy0 = 1'b0;
      repeat (5) begin
         step();
         chk("bp_idx", 64'(idx0), 64'(3));
         chk("bp_data", 64'(d0), 64'(4));
         chk("bp_valid", 64'(v0), 64'(1));
      end
      rdy0 = 1'b1;
      step();
      chk("bp_release_idx", 64'(idx0), 64'(4));
      chk("bp_release_data", 64'(d0), 64'(5));
      chk("m1_drained_valid", 64'(v1), 64'(0));
      chk("m1_drained_dirty", 64'(dirty1), 64'(0));

      // MODE 1 change detection
      drv[2] = 4'hA;
      drv[6] = 4'h5;
      upd = 8'h44;
      en = 1'b1;
      step();
      chk("chg_dirty", 64'(dirty1), 64'(8'h44));
      chk("chg_not_yet", 64'(v1), 64'(0));
      upd = '0;
      step();
      chk("chg_b1_valid", 64'(v1), 64'(1));
      chk("chg_b1_idx", 64'(idx1), 64'(2));
      chk("chg_b1_data", 64'(d1), 64'(4'hA));
      step();
      chk("chg_b2_idx", 64'(idx1), 64'(6));
      chk("chg_b2_data", 64'(d1), 64'(4'h5));
      step();
      chk("chg_idle", 64'(v1), 64'(0));
      upd = 8'h04;
      step();
      upd = '0;
      step();
      chk("same_no_beat", 64'(v1), 64'(0));
      chk("same_no_dirty", 64'(dirty1), 64'(0));
      drv[2] = 4'hB;
      upd = 8'h04;
      step();
      chk("chgB_dirty", 64'(dirty1), 64'(8'h04));
      upd = '0;
      step();
      chk("chgB_idx", 64'(idx1), 64'(2));
      chk("chgB_data", 64'(d1), 64'(4'hB));
      step();
      chk("chgB_idle", 64'(v1), 64'(0));

      // Capture on the channel being loaded
      drv[3] = 4'h1;
      upd = 8'h08;
      step();
      drv[3] = 4'h2;
      step();
      chk("coll_idx", 64'(idx1), 64'(3));
      chk("coll_data_old", 64'(d1), 64'(1));
      chk("coll_dirty_kept", 64'(dirty1), 64'(8'h08));
      upd = '0;
      step();
      chk("coll_next_idx", 64'(idx1), 64'(3));
      chk("coll_next_data", 64'(d1), 64'(2));
      step();
      chk("coll_idle", 64'(v1), 64'(0));

      // Fairness: ptr=1, ch0 re-dirtied each cycle, ch5 dirty once
      drv[0] = 4'h9;
      upd = 8'h01;
      step();
      upd = '0;
      step();
      chk("fair_setup_idx", 64'(idx1), 64'(0));
      drv[0] = 4'hA;
      drv[5] = 4'h3;
      upd = 8'h21;
      step();
      chk("fair_dirty", 64'(dirty1), 64'(8'h21));
      drv[0] = 4'hB;
      upd = 8'h01;
      step();
      chk("fair_first", 64'(idx1), 64'(5));
      drv[0] = 4'hC;
      step();
      chk("fair_second", 64'(idx1), 64'(0));
      drv[0] = 4'hD;
      step();
      chk("fair_third", 64'(idx1), 64'(0));
      upd = '0;
      en = 1'b0;
      repeat (3) step();

      // Asynchronous reset between edges with MODE 0 on idx 4
      guard = 0;
      while (midx[0] != 4 && guard < 20) begin
         step();
         guard++;
      end
      chk("pre_rst_idx", 64'(idx0), 64'(4));
      chk("pre_rst_valid", 64'(v0), 64'(1));
      #2;
      rst = 1'b1;
      #1;
      chk("arst_v0", 64'(v0), 64'(0));
      chk("arst_idx0", 64'(idx0), 64'(0));
      chk("arst_d0", 64'(d0), 64'(0));
      chk("arst_q0", 64'(q0), 64'(0));
      chk("arst_q1", 64'(q1), 64'(0));
      chk("arst_dirty1", 64'(dirty1), 64'(0));
      chk("arst_v1", 64'(v1), 64'(0));
      model_reset();
      #2;
      rst = 1'b0;
      step();
      chk("post_rst_v0", 64'(v0), 64'(1));
      chk("post_rst_idx0", 64'(idx0), 64'(0));
      chk("post_rst_v1", 64'(v1), 64'(0));

      // Random traffic against the model
      repeat (400) begin
         en = ($urandom_range(0, 7) != 0);
         upd = NCH'($urandom & $urandom);
         for (int c = 0; c < NCH; c++) drv[c] = W'($urandom);
         rdy0 = ($urandom_range(0, 3) != 0);
         rdy1 = ($urandom_range(0, 3) != 0);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
